rf_wb_arbiter: RTL

//  Sequences the single write port of the 32x64 integer register file.
//  Up to NREQ writeback sources (ALU, load unit, mul/div) compete for that port,
//  and a round-robin arbiter picks one each cycle.
//  A per-register busy scoreboard tracks in-flight destinations. It exposes operand

---
 rtl/rf_wb_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter for the register-file write port plus
// a per-register busy scoreboard guarding operand hazards and WAW issue.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*5-1:0]    req_dest,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 iss_valid,
    input  logic [4:0]           iss_dest,
    output logic                 iss_ready,
    input  logic [4:0]           rs1_sel,
    input  logic [4:0]           rs2_sel,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rf_we,
    output logic [4:0]           rf_dest,
    output logic [XLEN-1:0]      rf_data,
    output logic [31:0]          busy_mask
);
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0]   r_rr_ptr;
    logic            r_rf_we;
    logic [4:0]      r_rf_dest;
    logic [XLEN-1:0] r_rf_data;
    logic [31:0]     r_busy;
    logic [PW-1:0]   w_rot [NREQ];
    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_gidx;
    logic            w_any;
    logic [PW-1:0]   w_next_ptr;
    logic [4:0]      w_sel_dest;
    logic [XLEN-1:0] w_sel_data;
    logic [31:0]     w_clr;
    logic [31:0]     w_set;
    logic [31:0]     w_busy_nx;
    // w_rot[k] is the requester examined k-th, starting from the pointer
    for (genvar g = 0; g < NREQ; g++) begin : g_rot
        assign w_rot[g] = PW'((int'(r_rr_ptr) + g) % NREQ);
    end
    // descending scan so the earliest position in the search order wins
    always_comb begin
        w_gnt  = '0;
        w_gidx = '0;
        w_any  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[w_rot[k]]) begin
                w_gnt           = '0;
                w_gnt[w_rot[k]] = 1'b1;
                w_gidx          = w_rot[k];
                w_any           = 1'b1;
            end
        end
    end
    assign req_ready  = w_gnt;
    assign w_next_ptr = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    assign w_sel_dest = req_dest[5*w_gidx +: 5];
    assign w_sel_data = req_data[XLEN*w_gidx +: XLEN];
    assign iss_ready  = ~r_busy[iss_dest] | (iss_dest == 5'd0);
    assign rs1_busy   = r_busy[rs1_sel];
    assign rs2_busy   = r_busy[rs2_sel];
    // clear follows the visible write; a same-edge allocation wins over it
    assign w_clr      = r_rf_we ? (32'd1 << r_rf_dest) : 32'd0;
    assign w_set      = (iss_valid && iss_ready && iss_dest != 5'd0) ? (32'd1 << iss_dest) : 32'd0;
    assign w_busy_nx  = ((r_busy & ~w_clr) | w_set) & ~32'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_rf_we   <= 1'b0;
            r_rf_dest <= '0;
            r_rf_data <= '0;
            r_busy    <= '0;
        end else begin
            if (w_any) r_rr_ptr <= w_next_ptr;
            r_rf_we <= w_any && (w_sel_dest != 5'd0);
            if (w_any && w_sel_dest != 5'd0) begin
                r_rf_dest <= w_sel_dest;
                r_rf_data <= w_sel_data;
            end
            r_busy <= w_busy_nx;
        end
    end
    assign rf_we     = r_rf_we;
    assign rf_dest   = r_rf_dest;
    assign rf_data   = r_rf_data;
    assign busy_mask = r_busy;
endmodule
